syscall_string_printer: RTL and testbench

Services the print-string system call (`v0 == 4`) raised by the writeback stage. On a request it reads the NUL-terminated string at byte address `a0` out of data memory one word at a time and streams the characters to a console sink over a valid/ready handshake. It stalls the pipeline until the string is finished. It sits beside writeback, consuming `print_string`, `syscall_in` and `string_index`, and driving the hazard unit's stall input.

---
 rtl/syscall_pkg.sv | 15 +
 rtl/byte_lane_sel.sv | 18 +
 rtl/syscall_string_printer.sv | 119 +++++++++++
 tb/tb_syscall_string_printer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared types and constants for the print-string syscall service block.
package syscall_pkg;

  localparam logic [31:0] SYSCALL_PRINT_STRING = 32'd4;
  localparam logic [7:0]  CHAR_NUL             = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/byte_lane_sel.sv
// Big-endian byte lane select: lane 0 is the most significant byte of the word.
module byte_lane_sel (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = word_i[31:24];
    case (lane_i)
      2'd0:    byte_o = word_i[31:24];
      2'd1:    byte_o = word_i[23:16];
      2'd2:    byte_o = word_i[15:8];
      default: byte_o = word_i[7:0];
    endcase
  end

endmodule

// File: rtl/syscall_string_printer.sv
// Print-string syscall engine: fetches a NUL-terminated string word by word
// from data memory and streams its characters to the console sink.
module syscall_string_printer
  import syscall_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_in,
  input  logic        print_string,
  input  logic [31:0] string_index,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        stall,
  output logic        done,
  output logic        truncated
);

  localparam int unsigned     CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic [31:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        word_q, word_d;
  logic               truncated_q, truncated_d;
  logic [7:0]         cur_byte;
  logic               start;

  byte_lane_sel u_lane_sel (
    .word_i (word_q),
    .lane_i (ptr_q[1:0]),
    .byte_o (cur_byte)
  );

  assign start     = syscall_in & print_string & (state_q == ST_IDLE);
  // Combinational so the syscall is frozen from its very first writeback cycle.
  assign stall     = start | (state_q != ST_IDLE);
  assign truncated = truncated_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      truncated_q <= truncated_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    truncated_d = truncated_q;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    char_valid  = 1'b0;
    char_data   = '0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d       = string_index;
          cnt_d       = '0;
          truncated_d = 1'b0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = {ptr_q[31:2], 2'b00};
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        word_d  = mem_rdata;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        // The terminating NUL ends the call without being presented to the sink.
        if (cur_byte == CHAR_NUL) begin
          state_d = ST_DONE;
        end else begin
          char_valid = 1'b1;
          char_data  = cur_byte;
          if (char_ready) begin
            ptr_d = ptr_q + 32'd1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_MAX) begin
              truncated_d = 1'b1;
              state_d     = ST_DONE;
            end else if (ptr_d[1:0] == 2'b00) begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_syscall_string_printer.sv
// Self-checking bench for syscall_string_printer: a string-level reference model
// plus directed timing pins, run on a default instance and a MAX_LEN=4 instance.
module tb_syscall_string_printer;
  import syscall_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] v0;
  logic        print_string;
  logic [31:0] string_index;
  logic        sys        [2];
  logic        mem_rd_en  [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_rdata  [2];
  logic        char_valid [2];
  logic [7:0]  char_data  [2];
  logic        char_ready [2];
  logic        stall      [2];
  logic        done       [2];
  logic        truncated  [2];

  assign print_string = (v0 == SYSCALL_PRINT_STRING);

  syscall_string_printer dut0 (
    .clk(clk), .rst_n(rst_n), .syscall_in(sys[0]), .print_string(print_string),
    .string_index(string_index), .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]),
    .mem_rdata(mem_rdata[0]), .char_valid(char_valid[0]), .char_data(char_data[0]),
    .char_ready(char_ready[0]), .stall(stall[0]), .done(done[0]), .truncated(truncated[0])
  );

  syscall_string_printer #(.MAX_LEN(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .syscall_in(sys[1]), .print_string(print_string),
    .string_index(string_index), .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]),
    .mem_rdata(mem_rdata[1]), .char_valid(char_valid[1]), .char_data(char_data[1]),
    .char_ready(char_ready[1]), .stall(stall[1]), .done(done[1]), .truncated(truncated[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int max_len [2] = '{256, 4};
  int rdy_mode [2] = '{0, 0};

  logic [7:0]  mem [0:1023];
  logic [7:0]  exp_chr [2][$];
  logic [31:0] exp_adr [2][$];
  logic        exp_trn [2];
  int          acc_cyc [2][$];
  int          acc_dat [2][$];
  int          rd_cnt [2];
  int          stall_cnt [2];
  int          done_cnt [2] = '{0, 0};
  int          done_cyc [2];
  logic        hold [2] = '{1'b0, 1'b0};
  logic [7:0]  hold_data [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d got %h expected %h", nm, k, cyc, act, exp);
    end
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [9:0] w;
    w = {a[9:2], 2'b00};
    return {mem[w], mem[w + 10'd1], mem[w + 10'd2], mem[w + 10'd3]};
  endfunction

  // Data memory: one-cycle read latency per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_rd_en[k]) mem_rdata[k] <= rd_word(mem_addr[k]);
  end

  // Sink readiness: always ready, or ready one cycle in three.
  initial begin
    char_ready[0] = 1'b1;
    char_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        char_ready[k] = (rdy_mode[k] == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  // Reference model: the characters a call emits and the words it must read.
  task automatic model_req(input int k, input logic [31:0] a);
    int n;
    logic [31:0] ba, wa;
    logic [7:0] b;
    exp_chr[k].delete();
    exp_adr[k].delete();
    exp_trn[k] = 1'b0;
    n = 0;
    forever begin
      if (n == max_len[k]) begin
        exp_trn[k] = 1'b1;
        break;
      end
      ba = a + 32'(n);
      wa = {ba[31:2], 2'b00};
      if (exp_adr[k].size() == 0 || exp_adr[k][exp_adr[k].size() - 1] != wa)
        exp_adr[k].push_back(wa);
      b = mem[ba[9:0]];
      if (b == 8'h00) break;
      exp_chr[k].push_back(b);
      n++;
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        hold[k] = 1'b0;
      end else begin
        if (hold[k]) begin
          chk("hold_valid", k, 32'(char_valid[k]), 32'd1);
          chk("hold_data", k, 32'(char_data[k]), 32'(hold_data[k]));
        end
        hold[k]      = char_valid[k] && !char_ready[k];
        hold_data[k] = char_data[k];
        if (char_valid[k] || mem_rd_en[k] || done[k])
          chk("stall_busy", k, 32'(stall[k]), 32'd1);
        if (stall[k]) stall_cnt[k]++;
        if (mem_rd_en[k]) begin
          rd_cnt[k]++;
          chk("rd_addr", k, mem_addr[k],
              (exp_adr[k].size() == 0) ? 32'hFFFF_FFFF : exp_adr[k][0]);
          if (exp_adr[k].size() != 0) void'(exp_adr[k].pop_front());
        end
        if (char_valid[k] && char_ready[k]) begin
          acc_cyc[k].push_back(cyc);
          acc_dat[k].push_back(int'(char_data[k]));
          chk("char", k, 32'(char_data[k]),
              (exp_chr[k].size() == 0) ? 32'h100 : 32'(exp_chr[k][0]));
          if (exp_chr[k].size() != 0) void'(exp_chr[k].pop_front());
        end
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
          chk("chars_left", k, 32'(exp_chr[k].size()), 32'd0);
          chk("reads_left", k, 32'(exp_adr[k].size()), 32'd0);
          chk("truncated", k, 32'(truncated[k]), 32'(exp_trn[k]));
        end
      end
    end
  end

  function automatic int acc_c(input int k, input int i);
    if (i < acc_cyc[k].size()) return acc_cyc[k][i];
    return -1;
  endfunction

  function automatic int acc_d(input int k, input int i);
    if (i < acc_dat[k].size()) return acc_dat[k][i];
    return -1;
  endfunction

  // Called at posedge+1; t is the request cycle.
  task automatic request(input int k, input logic [31:0] a, output int t);
    model_req(k, a);
    acc_cyc[k].delete();
    acc_dat[k].delete();
    rd_cnt[k]    = 0;
    stall_cnt[k] = 0;
    t            = cyc;
    v0           = 32'd4;
    string_index = a;
    sys[k]       = 1'b1;
    @(posedge clk);
    #1;
    sys[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int c0;
    c0 = done_cnt[k];
    for (int i = 0; i < 200 && done_cnt[k] == c0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("done_seen", k, 32'(done_cnt[k]), 32'(c0 + 1));
  endtask

  task automatic put_str(input int a, input string s);
    for (int i = 0; i < s.len(); i++) mem[a + i] = s[i];
    mem[a + s.len()] = 8'h00;
  endtask

  initial begin
    int t;
    rst_n        = 1'b0;
    v0           = 32'd0;
    string_index = 32'd0;
    sys[0]       = 1'b0;
    sys[1]       = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    mem[10'h100] = 8'h48; mem[10'h101] = 8'h69; mem[10'h102] = 8'h00; mem[10'h103] = 8'h00;
    put_str(32'h203, "ABCDE");
    mem[10'h300] = 8'h00;
    put_str(32'h400, "0123456789");

    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rd_en", k, 32'(mem_rd_en[k]), 32'd0);
      chk("rst_addr", k, mem_addr[k], 32'd0);
      chk("rst_valid", k, 32'(char_valid[k]), 32'd0);
      chk("rst_data", k, 32'(char_data[k]), 32'd0);
      chk("rst_stall", k, 32'(stall[k]), 32'd0);
      chk("rst_done", k, 32'(done[k]), 32'd0);
      chk("rst_trunc", k, 32'(truncated[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Syscall with a different v0 is not serviced.
    rd_cnt[0] = 0;
    v0 = 32'd1; string_index = 32'h100; sys[0] = 1'b1;
    #1;
    chk("other_sys_stall", 0, 32'(stall[0]), 32'd0);
    @(posedge clk); #1;
    sys[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("other_sys_reads", 0, 32'(rd_cnt[0]), 32'd0);

    // "Hi" at 0x100.
    request(0, 32'h100, t);
    wait_done(0);
    chk("hi_c0", 0, 32'(acc_c(0, 0)), 32'(t + 3));
    chk("hi_d0", 0, 32'(acc_d(0, 0)), 32'h48);
    chk("hi_c1", 0, 32'(acc_c(0, 1)), 32'(t + 4));
    chk("hi_d1", 0, 32'(acc_d(0, 1)), 32'h69);
    chk("hi_done", 0, 32'(done_cyc[0]), 32'(t + 6));
    chk("hi_reads", 0, 32'(rd_cnt[0]), 32'd1);
    chk("hi_stall", 0, 32'(stall_cnt[0]), 32'd7);
    chk("hi_idle_stall", 0, 32'(stall[0]), 32'd0);

    // Unaligned "ABCDE" at 0x203, sink always ready.
    request(0, 32'h203, t);
    wait_done(0);
    chk("abc_cA", 0, 32'(acc_c(0, 0)), 32'(t + 3));
    chk("abc_cB", 0, 32'(acc_c(0, 1)), 32'(t + 6));
    chk("abc_cE", 0, 32'(acc_c(0, 4)), 32'(t + 9));
    chk("abc_dE", 0, 32'(acc_d(0, 4)), 32'h45);
    chk("abc_done", 0, 32'(done_cyc[0]), 32'(t + 13));
    chk("abc_reads", 0, 32'(rd_cnt[0]), 32'd3);

    // Same string, sink ready one cycle in three.
    rdy_mode[0] = 1;
    request(0, 32'h203, t);
    wait_done(0);
    rdy_mode[0] = 0;
    chk("slow_count", 0, 32'(acc_dat[0].size()), 32'd5);
    chk("slow_dC", 0, 32'(acc_d(0, 2)), 32'h43);

    // Empty string.
    request(0, 32'h300, t);
    wait_done(0);
    chk("empty_done", 0, 32'(done_cyc[0]), 32'(t + 4));
    chk("empty_count", 0, 32'(acc_dat[0].size()), 32'd0);
    chk("empty_trunc", 0, 32'(truncated[0]), 32'd0);

    // Ten characters on the default instance: no truncation.
    request(0, 32'h400, t);
    wait_done(0);
    chk("ten_count", 0, 32'(acc_dat[0].size()), 32'd10);
    chk("ten_done", 0, 32'(done_cyc[0]), 32'(t + 18));

    // Ten characters with MAX_LEN = 4.
    request(1, 32'h400, t);
    wait_done(1);
    chk("trunc_count", 1, 32'(acc_dat[1].size()), 32'd4);
    chk("trunc_c3", 1, 32'(acc_c(1, 3)), 32'(t + 6));
    chk("trunc_d3", 1, 32'(acc_d(1, 3)), 32'h33);
    chk("trunc_done", 1, 32'(done_cyc[1]), 32'(t + 7));
    repeat (5) @(posedge clk);
    #1;
    chk("trunc_held", 1, 32'(truncated[1]), 32'd1);
    request(1, 32'h300, t);
    chk("trunc_cleared", 1, 32'(truncated[1]), 32'd0);
    wait_done(1);

    // Reset while the second character is on offer.
    request(0, 32'h400, t);
    while (cyc != t + 4) begin
      @(posedge clk);
      #1;
    end
    #1;
    chk("pre_rst_valid", 0, 32'(char_valid[0]), 32'd1);
    chk("pre_rst_data", 0, 32'(char_data[0]), 32'h31);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 0, 32'(char_valid[0]), 32'd0);
    chk("rst_mid_stall", 0, 32'(stall[0]), 32'd0);
    chk("rst_mid_rd_en", 0, 32'(mem_rd_en[0]), 32'd0);
    chk("rst_mid_accepted", 0, 32'(acc_dat[0].size()), 32'd1);
    for (int k = 0; k < 2; k++) begin
      exp_chr[k].delete();
      exp_adr[k].delete();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    request(0, 32'h100, t);
    wait_done(0);
    chk("after_rst_d0", 0, 32'(acc_d(0, 0)), 32'h48);
    chk("after_rst_c0", 0, 32'(acc_c(0, 0)), 32'(t + 3));
    chk("after_rst_count", 0, 32'(acc_dat[0].size()), 32'd2);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
